// File: rtl/mult_seq32_if.sv
// ---------------------------------------------------------------------------
// mult_seq32_if
// Handshake and result bundle for the iterative multiplier.
//   start     : request, sampled only while the multiplier is idle
//   is_signed : 1 = two's-complement operands, 0 = unsigned
//   a, b      : multiplicand / multiplier, captured on the accepting edge
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse, hi/lo hold the new product
//   hi, lo    : upper / lower halves of the 2*WIDTH-bit product
// master = requester (drives start/operands), slave = multiplier.
// ---------------------------------------------------------------------------
interface mult_seq32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq32.sv
// ---------------------------------------------------------------------------
// mult_seq32
// Iterative shift-add multiplier for MUL/MULU. One multiplier bit is
// consumed per clock; a final SIGN cycle applies the result sign and
// writes HI/LO. DONE pulses WIDTH+1 edges after the accepting edge.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_seq32_if.slave (start/is_signed/a/b in, busy/done/hi/lo out)
// ---------------------------------------------------------------------------
module mult_seq32 #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_seq32_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   acc_reg;     // upper half of the running product
    logic [WIDTH-1:0]   mplier_reg;  // remaining multiplier bits / lower half
    logic [CNT_W-1:0]   cnt_reg;
    logic               neg_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum_next;    // carry kept in the top bit
    logic [2*WIDTH-1:0] prod_next;

    // Operand magnitudes. |-2^(W-1)| wraps to 2^(W-1), which is exactly the
    // right unsigned magnitude in WIDTH bits.
    always_comb begin
        abs_a = bus.a;
        abs_b = bus.b;
        if (bus.is_signed && bus.a[WIDTH-1]) begin
            abs_a = ~bus.a + WIDTH'(1);
        end
        if (bus.is_signed && bus.b[WIDTH-1]) begin
            abs_b = ~bus.b + WIDTH'(1);
        end
    end

    // One shift-add step and the sign-corrected final product.
    always_comb begin
        sum_next = {1'b0, acc_reg};
        if (mplier_reg[0]) begin
            sum_next = {1'b0, acc_reg} + {1'b0, mcand_reg};
        end
        prod_next = {acc_reg, mplier_reg};
        if (neg_reg) begin
            prod_next = ~{acc_reg, mplier_reg} + (2*WIDTH)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mcand_reg  <= abs_a;
                        mplier_reg <= abs_b;
                        neg_reg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_reg    <= '0;
                        cnt_reg    <= CNT_W'(WIDTH);
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    // Shift {carry, acc, mplier} right by one: the sum's LSB
                    // drops into the top of the lower half.
                    acc_reg    <= sum_next[WIDTH:1];
                    mplier_reg <= {sum_next[0], mplier_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= SIGN;
                    end
                end
                SIGN: begin
                    hi_reg    <= prod_next[2*WIDTH-1:WIDTH];
                    lo_reg    <= prod_next[WIDTH-1:0];
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mult_seq32.sv
// ---------------------------------------------------------------------------
// tb_mult_seq32
// Directed self-checking bench for mult_seq32 (WIDTH=32). Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mult_seq32;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mult_seq32_if #(.WIDTH(32)) bus ();

    mult_seq32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands with start=1, wait for the accepting edge, drop start.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    endtask

    // Count edges until done is seen; busy_n counts busy samples before it.
    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
        check("done_seen", {63'd0, bus.done}, 64'd1);
    endtask

    initial begin
        int n;
        int bn;
        int gap;
        logic stable;

        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: unsigned 3*5, latency and busy length
        start_op(32'd3, 32'd5, 1'b0);
        wait_done(n, bn);
        $display("op1 3*5 u: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, n);
        check("t1_latency", 64'(n), 64'd33);
        check("t1_busy_len", 64'(bn + 1), 64'd33);
        check("t1_busy_at_done", {63'd0, bus.busy}, 64'd0);
        check("t1_prod", {bus.hi, bus.lo}, 64'h00000000_0000000F);
        @(posedge clk); #1;
        check("t1_done_pulse", {63'd0, bus.done}, 64'd0);

        // 2: signed -7*6
        start_op(32'hFFFFFFF9, 32'h00000006, 1'b1);
        wait_done(n, bn);
        $display("op2 -7*6 s: hi=%h lo=%h", bus.hi, bus.lo);
        check("t2_prod", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFD6);

        // 3: extreme operands
        start_op(32'h80000000, 32'h80000000, 1'b1);
        wait_done(n, bn);
        $display("op3 min*min s: hi=%h lo=%h", bus.hi, bus.lo);
        check("t3_minmin", {bus.hi, bus.lo}, 64'h40000000_00000000);
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done(n, bn);
        $display("op3 max*max u: hi=%h lo=%h", bus.hi, bus.lo);
        check("t3_maxmax", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);

        // 4: start re-asserted mid-RUN is ignored
        start_op(32'd2, 32'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.a         = 32'd9;
        bus.b         = 32'd9;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n, bn);
        $display("op4 2*2 with ignored start: hi=%h lo=%h", bus.hi, bus.lo);
        check("t4_latency", 64'(n + 5), 64'd33);
        check("t4_prod", {bus.hi, bus.lo}, 64'h00000000_00000004);

        // 5: asynchronous reset during iteration 10
        start_op(32'd5, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("op5 reset mid-run: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        check("t5_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("t5_rst_done", {63'd0, bus.done}, 64'd0);
        check("t5_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) stable = 1'b0;
        end
        check("t5_no_spurious", {63'd0, stable}, 64'd1);
        start_op(32'd4, 32'd4, 1'b0);
        wait_done(n, bn);
        $display("op5 4*4 after reset: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, n);
        check("t5_latency", 64'(n), 64'd33);
        check("t5_prod", {bus.hi, bus.lo}, 64'h00000000_00000010);

        // 6: start held high, back-to-back operations
        bus.a         = 32'd0;
        bus.b         = 32'h12345678;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.a         = 32'hFFFFFFFF;
        bus.b         = 32'hFFFFFFFF;
        bus.is_signed = 1'b1;
        wait_done(n, bn);
        $display("op6a 0*12345678 u: hi=%h lo=%h", bus.hi, bus.lo);
        check("t6_first_prod", {bus.hi, bus.lo}, 64'd0);
        gap    = 0;
        stable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            gap++;
            if (gap == 1) begin
                bus.start = 1'b0;
                check("t6_done_drop", {63'd0, bus.done}, 64'd0);
                check("t6_rebusy", {63'd0, bus.busy}, 64'd1);
            end
            if (bus.done) break;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0) stable = 1'b0;
        end
        $display("op6b -1*-1 s: hi=%h lo=%h gap=%0d", bus.hi, bus.lo, gap);
        check("t6_gap", 64'(gap), 64'd34);
        check("t6_hilo_stable", {63'd0, stable}, 64'd1);
        check("t6_second_prod", {bus.hi, bus.lo}, 64'h00000000_00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
